// File: rtl/subkey_word_stream.sv
// Threefish key-schedule sequencer: captures key/tweak, builds the parity word
// and t2, then streams subkey words s=0..NS-1 over a valid/ready handshake.
module subkey_word_stream #(
   parameter int NW = 16,
   parameter int NS = 21
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load_i,
   input  logic [64*NW-1:0]        key_i,
   input  logic [127:0]            tweak_i,
   output logic                    key_ready_o,
   input  logic                    next_i,
   output logic                    word_valid_o,
   input  logic                    word_ready_i,
   output logic [63:0]             word_o,
   output logic [$clog2(NW)-1:0]   word_idx_o,
   output logic [4:0]              subkey_idx_o,
   output logic                    last_word_o,
   output logic                    done_o
);
   localparam int IW = $clog2(NW);
   localparam int KW = $clog2(NW + 1);
   localparam logic [63:0] KS_CONST = 64'h1BD11BDAA9FC1A22;

   if (!(NW == 4 || NW == 8 || NW == 16)) begin : g_bad_nw
      $error("subkey_word_stream: NW must be 4, 8 or 16");
   end

   typedef enum logic [2:0] {IDLE, PARITY, READY, STREAM, DONE} state_t;
   state_t state, state_nxt;

   // k[NW] is the extended parity word; t[2] = t0 ^ t1
   logic [63:0]   k [0:NW];
   logic [63:0]   t [0:2];
   logic [4:0]    s;
   logic [KW-1:0] bptr, gen_k, sel_k;
   logic [1:0]    tptr, tptr1;
   logic [IW-1:0] gen_i, sel_i;
   logic [63:0]   word_nxt;
   logic          fire, fire_last, advance;

   function automatic logic [KW-1:0] kinc(input logic [KW-1:0] p);
      return (p == KW'(NW)) ? '0 : p + 1'b1;
   endfunction

   assign fire      = word_valid_o && word_ready_i;
   assign fire_last = (state == STREAM) && fire && last_word_o;
   assign advance   = !load_i && (((state == READY) && next_i) ||
                                  ((state == STREAM) && fire && !last_word_o));
   assign sel_i     = (state == READY) ? '0 : gen_i;
   assign sel_k     = (state == READY) ? bptr : gen_k;
   assign tptr1     = (tptr == 2'd2) ? 2'd0 : tptr + 2'd1;

   always_comb begin
      word_nxt = k[sel_k];
      if (sel_i == IW'(NW - 3))      word_nxt = word_nxt + t[tptr];
      else if (sel_i == IW'(NW - 2)) word_nxt = word_nxt + t[tptr1];
      else if (sel_i == IW'(NW - 1)) word_nxt = word_nxt + {59'd0, s};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (load_i) state_nxt = PARITY;
      else begin
         case (state)
            PARITY: if (gen_i == IW'(NW - 1)) state_nxt = READY;
            READY:  if (next_i) state_nxt = STREAM;
            STREAM: if (fire_last) state_nxt = (s == 5'(NS - 1)) ? DONE : READY;
            default: ;
         endcase
      end
   end

   always_comb begin
      key_ready_o = (state == READY);
      done_o      = (state == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int j = 0; j <= NW; j++) k[j] <= '0;
         for (int j = 0; j < 3; j++) t[j] <= '0;
         s            <= '0;
         bptr         <= '0;
         tptr         <= '0;
         gen_i        <= '0;
         gen_k        <= '0;
         word_valid_o <= 1'b0;
         word_o       <= '0;
         word_idx_o   <= '0;
         subkey_idx_o <= '0;
         last_word_o  <= 1'b0;
      end else if (load_i) begin
         for (int j = 0; j < NW; j++) k[j] <= key_i[64*j +: 64];
         k[NW]        <= KS_CONST;
         t[0]         <= tweak_i[63:0];
         t[1]         <= tweak_i[127:64];
         t[2]         <= tweak_i[63:0] ^ tweak_i[127:64];
         s            <= '0;
         bptr         <= '0;
         tptr         <= '0;
         gen_i        <= '0;
         gen_k        <= '0;
         word_valid_o <= 1'b0;
      end else begin
         if (state == PARITY) begin
            k[NW] <= k[NW] ^ k[gen_i];
            gen_i <= gen_i + 1'b1;
         end
         if (advance) begin
            word_o       <= word_nxt;
            word_idx_o   <= sel_i;
            subkey_idx_o <= s;
            last_word_o  <= (sel_i == IW'(NW - 1));
            word_valid_o <= 1'b1;
            gen_i        <= sel_i + 1'b1;
            gen_k        <= kinc(sel_k);
         end
         // subkey finished: step the three wrap-around pointers instead of dividing
         if (fire_last) begin
            word_valid_o <= 1'b0;
            if (s != 5'(NS - 1)) begin
               s    <= s + 5'd1;
               bptr <= kinc(bptr);
               tptr <= tptr1;
            end
         end
      end
   end
endmodule

// File: tb/tb_subkey_word_stream.sv
// Directed bench: NW=4/NS=19 and NW=16/NS=21 instances against hand-computed words.
module tb_subkey_word_stream;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [63:0] P4 = 64'h1BD11BDAA9FC1A26;

   logic          rst, load4, next4, ready4, kr4, v4, l4, d4;
   logic [255:0]  key4;
   logic [127:0]  tw4;
   logic [63:0]   w4;
   logic [1:0]    wi4;
   logic [4:0]    si4;

   logic          rst16, load16, next16, ready16, kr16, v16, l16, d16;
   logic [1023:0] key16;
   logic [127:0]  tw16;
   logic [63:0]   w16;
   logic [3:0]    wi16;
   logic [4:0]    si16;

   int n_cmp = 0, n_bad = 0;
   logic [63:0] cw [0:15];

   subkey_word_stream #(.NW(4), .NS(19)) u4 (
      .clk(clk), .rst(rst), .load_i(load4), .key_i(key4), .tweak_i(tw4),
      .key_ready_o(kr4), .next_i(next4), .word_valid_o(v4), .word_ready_i(ready4),
      .word_o(w4), .word_idx_o(wi4), .subkey_idx_o(si4), .last_word_o(l4), .done_o(d4));

   subkey_word_stream #(.NW(16), .NS(21)) u16 (
      .clk(clk), .rst(rst16), .load_i(load16), .key_i(key16), .tweak_i(tw16),
      .key_ready_o(kr16), .next_i(next16), .word_valid_o(v16), .word_ready_i(ready16),
      .word_o(w16), .word_idx_o(wi16), .subkey_idx_o(si16), .last_word_o(l16), .done_o(d16));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // independent reference for key 1..4, t0=0x10, t1=0x20
   function automatic logic [63:0] ref4(input int sk, input int i);
      logic [63:0] kk [0:4];
      logic [63:0] tt [0:2];
      logic [63:0] w;
      kk[0] = 64'd1; kk[1] = 64'd2; kk[2] = 64'd3; kk[3] = 64'd4; kk[4] = P4;
      tt[0] = 64'h10; tt[1] = 64'h20; tt[2] = 64'h30;
      w = kk[(sk + i) % 5];
      if (i == 1) w = w + tt[sk % 3];
      if (i == 2) w = w + tt[(sk + 1) % 3];
      if (i == 3) w = w + 64'(sk);
      return w;
   endfunction

   task automatic load_a4(input logic [255:0] key, input logic [127:0] tw);
      int n;
      key4 = key; tw4 = tw; load4 = 1'b1;
      tick;
      load4 = 1'b0;
      n = 0;
      while (!kr4 && n < 20) begin tick; n++; end
      chk("parity_latency4", 64'(n), 64'd4);
   endtask

   task automatic req4;
      int n;
      n = 0;
      while (!kr4 && n < 20) begin tick; n++; end
      chk("key_ready4", 64'(kr4), 64'd1);
      next4 = 1'b1;
      tick;
      next4 = 1'b0;
      chk("first_valid4", 64'(v4), 64'd1);
   endtask

   task automatic collect4(input int sk, input bit stall);
      int got, cyc;
      logic [63:0] hw;
      logic [1:0]  hi;
      logic [4:0]  hs;
      got = 0; cyc = 0;
      while (got < 4 && cyc < 200) begin
         ready4 = stall ? ((cyc == 0) ? 1'b0 : 1'($urandom_range(0, 1))) : 1'b1;
         if (v4 && !ready4) begin
            hw = w4; hi = wi4; hs = si4;
            tick; cyc++;
            chk("stall_word", w4, hw);
            chk("stall_idx", 64'(wi4), 64'(hi));
            chk("stall_subkey", 64'(si4), 64'(hs));
            continue;
         end
         if (v4) begin
            cw[got] = w4;
            chk("word_idx4", 64'(wi4), 64'(got));
            chk("subkey_idx4", 64'(si4), 64'(sk));
            chk("last_word4", 64'(l4), 64'(got == 3));
            got++;
         end
         tick; cyc++;
      end
      ready4 = 1'b1;
      chk("collect4_count", 64'(got), 64'd4);
      chk("valid_drop4", 64'(v4), 64'd0);
   endtask

   initial begin
      int n;
      bit seen_last;
      rst = 1'b1; rst16 = 1'b1;
      load4 = 0; next4 = 0; ready4 = 1; key4 = '0; tw4 = '0;
      load16 = 0; next16 = 0; ready16 = 1; key16 = '0; tw16 = '0;
      tick; tick;
      chk("rst_valid4", 64'(v4), 64'd0);
      chk("rst_word4", w4, 64'd0);
      chk("rst_ready4", 64'(kr4), 64'd0);
      chk("rst_done4", 64'(d4), 64'd0);
      chk("rst_last4", 64'(l4), 64'd0);
      chk("rst_valid16", 64'(v16), 64'd0);
      #2 rst = 1'b0; rst16 = 1'b0;
      tick;

      // key 1,2,3,4 ; t0=0x10 t1=0x20
      load_a4({64'd4, 64'd3, 64'd2, 64'd1}, {64'h20, 64'h10});
      req4; collect4(0, 1'b0);
      chk("s0w0", cw[0], 64'h1);
      chk("s0w1", cw[1], 64'h12);
      chk("s0w2", cw[2], 64'h23);
      chk("s0w3", cw[3], 64'h4);
      req4; collect4(1, 1'b1);
      chk("s1w0", cw[0], 64'h2);
      chk("s1w1", cw[1], 64'h23);
      chk("s1w2", cw[2], 64'h34);
      chk("s1w3", cw[3], 64'h1BD11BDAA9FC1A27);
      for (int sk = 2; sk < 19; sk++) begin
         req4; collect4(sk, sk[0]);
         for (int i = 0; i < 4; i++) chk("model_word4", cw[i], ref4(sk, i));
      end
      chk("s18w0", cw[0], 64'h4);
      chk("s18w1", cw[1], 64'h1BD11BDAA9FC1A36);
      chk("s18w2", cw[2], 64'h21);
      chk("s18w3", cw[3], 64'h14);
      chk("done4", 64'(d4), 64'd1);
      next4 = 1'b1; tick; tick; next4 = 1'b0;
      chk("done_next_ignored", 64'(v4), 64'd0);
      chk("done_held", 64'(d4), 64'd1);
      chk("done_not_ready", 64'(kr4), 64'd0);

      // load mid-stream at word 2
      load_a4({64'd4, 64'd3, 64'd2, 64'd1}, {64'h20, 64'h10});
      chk("done_cleared", 64'(d4), 64'd0);
      req4;
      n = 0;
      while (!(v4 && wi4 == 2'd2) && n < 10) begin tick; n++; end
      chk("reach_word2", 64'(wi4), 64'd2);
      key4 = {64'd8, 64'd7, 64'd6, 64'd5}; tw4 = '0; load4 = 1'b1;
      tick;
      load4 = 1'b0;
      chk("load_drop_valid", 64'(v4), 64'd0);
      n = 0;
      while (!kr4 && n < 20) begin tick; n++; end
      chk("reload_latency", 64'(n), 64'd4);
      req4;
      chk("reload_subkey", 64'(si4), 64'd0);
      chk("reload_idx", 64'(wi4), 64'd0);
      chk("reload_word", w4, 64'd5);

      // NW=16 all-ones key and tweak
      key16 = '1; tw16 = '1; load16 = 1'b1;
      tick;
      load16 = 1'b0;
      n = 0;
      while (!kr16 && n < 40) begin tick; n++; end
      chk("parity_latency16", 64'(n), 64'd16);
      next16 = 1'b1; tick; next16 = 1'b0;
      seen_last = 1'b0;
      n = 0;
      while (!seen_last && n < 60) begin
         if (v16) begin
            cw[wi16] = w16;
            seen_last = l16;
         end
         tick; n++;
      end
      chk("last16_seen", 64'(seen_last), 64'd1);
      chk("s0w0_16", cw[0], 64'hFFFFFFFFFFFFFFFF);
      chk("s0w13_16", cw[13], 64'hFFFFFFFFFFFFFFFE);
      chk("s0w14_16", cw[14], 64'hFFFFFFFFFFFFFFFE);
      chk("s0w15_16", cw[15], 64'hFFFFFFFFFFFFFFFF);

      // second subkey stalled, then async reset between edges
      ready16 = 1'b0;
      n = 0;
      while (!kr16 && n < 20) begin tick; n++; end
      next16 = 1'b1; tick; next16 = 1'b0;
      tick;
      chk("stall16_valid", 64'(v16), 64'd1);
      chk("stall16_subkey", 64'(si16), 64'd1);
      #2 rst16 = 1'b1;
      #1;
      chk("arst_valid16", 64'(v16), 64'd0);
      chk("arst_word16", w16, 64'd0);
      chk("arst_subkey16", 64'(si16), 64'd0);
      chk("arst_ready16", 64'(kr16), 64'd0);
      chk("arst_done16", 64'(d16), 64'd0);
      rst16 = 1'b0;
      ready16 = 1'b1;
      tick;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/subkey_word_stream.md
Name: subkey_word_stream

Overview:
- Parametrised Threefish key-schedule sequencer; successor to the fixed 13/14/15 subkey word-select mux.
- Captures a key and tweak, then computes the extended key parity word and the third tweak word.
- Streams every subkey word by word over a valid/ready handshake, covering subkeys 0..NS-1.
- Sits between the key/tweak registers and the Threefish round datapath, which consumes one 64-bit subkey word per accepted beat.

Parameters:
- NW, 16, words per block; legal values 4, 8, 16. Other values are an elaboration error.
- NS, 21, number of subkeys per block (NW=16 with 80 rounds gives 21; NW=4/8 with 72 rounds gives 19).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- load_i  in  1  capture key_i/tweak_i; accepted in any state.
- key_i  in  64*NW  key words; word j occupies bits [64j+63:64j].
- tweak_i  in  128  t0 in [63:0], t1 in [127:64].
- key_ready_o  out  1  parity done, sequencer in READY.
- next_i  in  1  request next subkey; sampled only in READY.
- word_valid_o  out  1  word_o valid.
- word_ready_i  in  1  consumer accepts the word.
- word_o  out  64  subkey word.
- word_idx_o  out  log2(NW)  word index i of word_o.
- subkey_idx_o  out  5  subkey index s of word_o.
- last_word_o  out  1  word_o is word NW-1 of its subkey.
- done_o  out  1  all NS subkeys delivered; held until the next load_i.

Behaviour:
- Reset: all outputs 0; state IDLE; key, tweak and parity registers 0.

States:
- IDLE: on load_i -> PARITY.
- PARITY: accumulates kNW = 0x1BD11BDAA9FC1A22 ^ k0 ^ ... ^ k(NW-1), one word per cycle, over NW cycles. Also computes t2 = t0 ^ t1. Then -> READY with s=0.
- READY: key_ready_o=1. next_i -> STREAM with i=0.
- STREAM: emits words i=0..NW-1. When the last word is accepted:
  - s < NS-1: s++ and -> READY.
  - s = NS-1: -> DONE.
- DONE: done_o=1. Only load_i exits.

Load behaviour:
- load_i captures key/tweak in the same cycle, in any state.
- It restarts PARITY and clears s, i, done_o, key_ready_o and word_valid_o on the next edge.
- An in-flight word is dropped.

Word formula (mod NW+1 index, all additions mod 2^64, carry discarded):
- Base: k[(s+i) mod (NW+1)].
- i = NW-3: add t[s mod 3].
- i = NW-2: add t[(s+1) mod 3].
- i = NW-1: add s, zero-extended.
- No divider is used. The base pointer s mod (NW+1), the word pointer and the tweak pointer s mod 3 are maintained incrementally with wrap-around: NW -> 0 and 2 -> 0.

Handshake:
- word_o, word_idx_o, subkey_idx_o and last_word_o are registered and change only when !word_valid_o || word_ready_i.
- They are held stable while word_valid_o && !word_ready_i.
- Throughput is 1 word/cycle with word_ready_i held high.
- Latency: next_i in READY -> first word_valid_o on the following edge.
- word_valid_o drops the cycle after the last word is accepted.
- next_i outside READY is ignored; it is not queued.
- next_i and load_i in the same cycle: load_i wins.

Test Plan:
1. NW=4, NS=19, key 1,2,3,4, t0=0x10, t1=0x20, load, word_ready_i=1 -> key_ready_o asserted 4 cycles after PARITY entry; next_i -> subkey 0 words 0x1, 0x12, 0x23, 0x4, with last_word_o on the 4th word.
2. Same setup, second next_i -> subkey 1 words 0x2, 0x23, 0x34, 0x1BD11BDAA9FC1A27 (kNW+1).
3. Random word_ready_i stalls during subkey 1 -> word_o, word_idx_o and subkey_idx_o stable while stalled; sequence identical to scenario 2.
4. Run all 19 subkeys -> subkey 18 = k[18 mod 5]=k3 ... with s=18 added to word 3; done_o=1 after its last accept; further next_i ignored.
5. load_i asserted mid-STREAM (word 2) -> word_valid_o=0 next cycle, then PARITY restarts with the new key; subkey_idx_o restarts at 0.
6. NW=16, all-ones key and tweak -> carries wrap mod 2^64 (word 13 of s=0 = 0xFFFFFFFFFFFFFFFE); rst asserted mid-stream clears all outputs asynchronously.
